// File: rtl/sram_arbiter_pkg.sv
// Shared types and default widths for the two-port SRAM arbiter.
package sram_arbiter_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;

    // Controller phase: INIT clears the array (optionally), RUN serves requesters.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Identifies which requester a command or response belongs to.
    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin grant. A lone requester is granted immediately; on a
// conflict the port that was not granted most recently wins.
module sram_rr_arb2
    import sram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    // Port that wins the next conflict; port 0 after reset.
    port_id_t prio;

    // Grant decision from current requests and the priority pointer.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (enable) begin
            if (valid0 && valid1) begin
                grant0 = (prio == PORT0);
                grant1 = (prio == PORT1);
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

    // Pointer moves to the other port only when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= PORT0;
        end else if (grant0) begin
            prio <= PORT1;
        end else if (grant1) begin
            prio <= PORT0;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester front end for a single-port synchronous SRAM: optional
// zero-fill after reset, round-robin command acceptance, and a two-deep tag
// pipeline that routes read data back to the issuing requester.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [ADDR_W-1:0] sram_addr0,
    output logic [DATA_W-1:0] sram_din0,
    input  logic [DATA_W-1:0] sram_dout0,

    output logic              init_done
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;

    logic              grant0;
    logic              grant1;
    logic              accept;
    port_id_t          cmd_port;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // In-flight read tags: p0 = command on the SRAM pins, p1 = SRAM executing.
    logic              rd_vld_p0;
    port_id_t          rd_port_p0;
    logic              rd_vld_p1;
    port_id_t          rd_port_p1;

    sram_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state == RUN),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Select the winning command; grants are one-hot so grant1 picks the port.
    always_comb begin
        accept    = grant0 | grant1;
        cmd_port  = grant1 ? PORT1 : PORT0;
        cmd_we    = grant1 ? req1_we    : req0_we;
        cmd_addr  = grant1 ? req1_addr  : req0_addr;
        cmd_wdata = grant1 ? req1_wdata : req0_wdata;
    end

    // Leave INIT after the last clear write, or immediately when clearing is off.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT: begin
                if (CLEAR_ON_RESET == 0 || clr_cnt == '1) begin
                    state_nxt = RUN;
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    // State, clear address counter and the sticky init_done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_done <= (state_nxt == RUN);
            if (state == INIT) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // SRAM pins: clear writes during INIT, accepted commands during RUN, idle otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_csb0  <= 1'b1;
            sram_web0  <= 1'b1;
            sram_addr0 <= '0;
            sram_din0  <= '0;
        end else if (state == INIT) begin
            if (CLEAR_ON_RESET != 0) begin
                sram_csb0  <= 1'b0;
                sram_web0  <= 1'b0;
                sram_addr0 <= clr_cnt;
                sram_din0  <= '0;
            end else begin
                sram_csb0 <= 1'b1;
                sram_web0 <= 1'b1;
            end
        end else if (accept) begin
            sram_csb0  <= 1'b0;
            sram_web0  <= ~cmd_we;
            sram_addr0 <= cmd_addr;
            sram_din0  <= cmd_wdata;
        end else begin
            sram_csb0 <= 1'b1;
            sram_web0 <= 1'b1;
        end
    end

    // Tag pipeline follows each read through the SRAM's two-edge latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p0  <= 1'b0;
            rd_port_p0 <= PORT0;
            rd_vld_p1  <= 1'b0;
            rd_port_p1 <= PORT0;
        end else begin
            rd_vld_p0  <= accept & ~cmd_we;
            rd_port_p0 <= cmd_port;
            rd_vld_p1  <= rd_vld_p0;
            rd_port_p1 <= rd_port_p0;
        end
    end

    // Capture SRAM output and pulse the response of the port that issued the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= rd_vld_p1 && (rd_port_p1 == PORT0);
            rsp1_valid <= rd_vld_p1 && (rd_port_p1 == PORT1);
            if (rd_vld_p1 && (rd_port_p1 == PORT0)) begin
                rsp0_rdata <= sram_dout0;
            end
            if (rd_vld_p1 && (rd_port_p1 == PORT1)) begin
                rsp1_rdata <= sram_dout0;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM, reference memory
// and a response scoreboard keyed by port, data and arrival cycle.
module tb_sram_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;

    typedef struct {
        logic  port;
        logic [DW-1:0] data;
        int    due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          sram_csb0, sram_web0, init_done;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;

    // second instance without clearing
    logic          rst2_n = 1'b0;
    logic          d2_valid0 = 1'b0, d2_we0 = 1'b0, d2_zero = 1'b0;
    logic [AW-1:0] d2_addr0 = '0, d2_addr_zero = '0;
    logic [DW-1:0] d2_data_zero = '0;
    logic          d2_ready0, d2_ready1, d2_rsp0_valid, d2_rsp1_valid;
    logic [DW-1:0] d2_rsp0_rdata, d2_rsp1_rdata, d2_din;
    logic          d2_csb, d2_web, d2_init_done;
    logic [AW-1:0] d2_sram_addr;

    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic          s_act = 1'b0, s_we_n = 1'b1;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_din = '0;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    exp_t          sb[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_dout0(sram_dout0), .init_done(init_done)
    );

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(0)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .req0_valid(d2_valid0), .req0_ready(d2_ready0), .req0_we(d2_we0),
        .req0_addr(d2_addr0), .req0_wdata(d2_data_zero),
        .req1_valid(d2_zero), .req1_ready(d2_ready1), .req1_we(d2_zero),
        .req1_addr(d2_addr_zero), .req1_wdata(d2_data_zero),
        .rsp0_valid(d2_rsp0_valid), .rsp0_rdata(d2_rsp0_rdata),
        .rsp1_valid(d2_rsp1_valid), .rsp1_rdata(d2_rsp1_rdata),
        .sram_csb0(d2_csb), .sram_web0(d2_web), .sram_addr0(d2_sram_addr),
        .sram_din0(d2_din), .sram_dout0(d2_data_zero), .init_done(d2_init_done)
    );

    // SRAM samples pins on the rising edge and executes on the falling edge.
    always @(posedge clk) begin
        s_act  <= !sram_csb0;
        s_we_n <= sram_web0;
        s_addr <= sram_addr0;
        s_din  <= sram_din0;
    end

    always @(negedge clk) begin
        if (s_act) begin
            if (!s_we_n) sram_mem[s_addr] <= s_din;
            else         sram_dout0 <= sram_mem[s_addr];
        end
    end

    // One clock, then score any response against the queue.
    task automatic step();
        exp_t e;
        logic gp;
        logic [DW-1:0] gd;
        @(posedge clk);
        #1;
        cyc++;
        if (rsp0_valid === 1'b1 && rsp1_valid === 1'b1) begin
            tests++; fails++;
            $display("FAIL rsp_both cyc=%0d got both valid, required at most one", cyc);
        end else if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
            gp = rsp1_valid;
            gd = rsp1_valid ? rsp1_rdata : rsp0_rdata;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected cyc=%0d got port%0d data=%h, required no response", cyc, gp, gd);
            end else begin
                e = sb.pop_front();
                if (gp !== e.port || gd !== e.data || cyc != e.due) begin
                    fails++;
                    $display("FAIL rsp_match got port%0d data=%h cyc=%0d, required port%0d data=%h cyc=%0d",
                             gp, gd, cyc, e.port, e.data, e.due);
                end
            end
        end
        if (sb.size() > 0 && sb[0].due < cyc) begin
            tests++; fails++;
            $display("FAIL rsp_missing got none by cyc=%0d, required port%0d data=%h at cyc=%0d",
                     cyc, sb[0].port, sb[0].data, sb[0].due);
            void'(sb.pop_front());
        end
    endtask

    task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    endtask

    task automatic push_read(input logic p, input logic [AW-1:0] a);
        exp_t e;
        e.port = p; e.data = ref_mem[a]; e.due = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 1100) begin
            step();
            n++;
        end
        tests++;
        if (init_done !== 1'b1) begin
            fails++;
            $display("FAIL init_timeout init_done=%b after %0d cycles, required 1", init_done, n);
        end
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    endtask

    task automatic test_reset();
        int bad;
        int rdy_bad;
        drive0(0, 0, '0, '0); drive1(0, 0, '0, '0);
        rst_n = 1'b0;
        step(); step();
        tests++;
        if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1) begin
            fails++; $display("FAIL reset_ctl csb=%b web=%b, required 1 1", sram_csb0, sram_web0);
        end
        tests++;
        if (sram_addr0 !== '0 || sram_din0 !== '0) begin
            fails++; $display("FAIL reset_bus addr=%h din=%h, required 0 0", sram_addr0, sram_din0);
        end
        tests++;
        if (rsp0_rdata !== '0 || rsp1_rdata !== '0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || init_done !== 1'b0) begin
            fails++; $display("FAIL reset_rsp rdata=%h/%h valid=%b%b init_done=%b, required zeros",
                              rsp0_rdata, rsp1_rdata, rsp0_valid, rsp1_valid, init_done);
        end
        rst_n = 1'b1;
        drive0(1, 0, 10'h3FF, '0); drive1(1, 0, 10'h001, '0);
        bad = 0; rdy_bad = 0;
        for (int k = 0; k < (1 << AW); k++) begin
            #1;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) rdy_bad++;
            step();
            if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== AW'(k) || sram_din0 !== '0) bad++;
            if (init_done !== (k == (1 << AW) - 1)) bad++;
        end
        drive0(0, 0, '0, '0); drive1(0, 0, '0, '0);
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL init_sequence got %0d bad cycles, required 0", bad);
        end
        tests++;
        if (rdy_bad != 0) begin
            fails++; $display("FAIL init_ready got %0d cycles with ready high, required 0", rdy_bad);
        end
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    endtask

    task automatic test_no_clear();
        tests++;
        if (d2_csb !== 1'b1 || d2_init_done !== 1'b0 || d2_ready0 !== 1'b0) begin
            fails++; $display("FAIL noclr_reset csb=%b init_done=%b ready=%b, required 1 0 0", d2_csb, d2_init_done, d2_ready0);
        end
        rst2_n = 1'b1;
        d2_valid0 = 1'b1; d2_we0 = 1'b0; d2_addr0 = 10'h005;
        #1;
        tests++;
        if (d2_ready0 !== 1'b0 || d2_init_done !== 1'b0) begin
            fails++; $display("FAIL noclr_init ready=%b init_done=%b, required 0 0", d2_ready0, d2_init_done);
        end
        step();
        tests++;
        if (d2_init_done !== 1'b1 || d2_csb !== 1'b1 || d2_ready0 !== 1'b1) begin
            fails++; $display("FAIL noclr_run init_done=%b csb=%b ready=%b, required 1 1 1", d2_init_done, d2_csb, d2_ready0);
        end
        step();
        d2_valid0 = 1'b0;
        tests++;
        if (d2_csb !== 1'b0 || d2_web !== 1'b1 || d2_sram_addr !== 10'h005) begin
            fails++; $display("FAIL noclr_access csb=%b web=%b addr=%h, required 0 1 005", d2_csb, d2_web, d2_sram_addr);
        end
        step(); step();
        tests++;
        if (d2_rsp0_valid !== 1'b1 || d2_rsp1_valid !== 1'b0 || d2_rsp0_rdata !== 8'h00) begin
            fails++; $display("FAIL noclr_rsp valid=%b%b data=%h, required 1 0 00", d2_rsp0_valid, d2_rsp1_valid, d2_rsp0_rdata);
        end
    endtask

    task automatic test_read_clear();
        drive0(1, 0, 10'h3FF, '0);
        #1;
        tests++;
        if (req0_ready !== 1'b1) begin
            fails++; $display("FAIL rdclr_ready ready0=%b, required 1", req0_ready);
        end
        push_read(1'b0, 10'h3FF);
        step();
        drive0(0, 0, '0, '0);
        repeat (4) step();
    endtask

    task automatic test_write_read();
        drive0(1, 1, 10'h3A5, 8'hC3);
        #1;
        tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            fails++; $display("FAIL wr_ready ready=%b%b, required 0 1 (p1 p0)", req1_ready, req0_ready);
        end
        ref_mem[10'h3A5] = 8'hC3;
        step();
        tests++;
        if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== 10'h3A5 || sram_din0 !== 8'hC3) begin
            fails++; $display("FAIL wr_pins csb=%b web=%b addr=%h din=%h, required 0 0 3a5 c3",
                              sram_csb0, sram_web0, sram_addr0, sram_din0);
        end
        drive0(1, 0, 10'h3A5, '0);
        #1;
        tests++;
        if (req0_ready !== 1'b1) begin
            fails++; $display("FAIL rd_ready ready0=%b, required 1", req0_ready);
        end
        push_read(1'b0, 10'h3A5);
        step();
        drive0(0, 0, '0, '0);
        tests++;
        if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b1 || sram_addr0 !== 10'h3A5) begin
            fails++; $display("FAIL rd_pins csb=%b web=%b addr=%h, required 0 1 3a5", sram_csb0, sram_web0, sram_addr0);
        end
        step();
        tests++;
        if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1) begin
            fails++; $display("FAIL idle_pins csb=%b web=%b, required 1 1", sram_csb0, sram_web0);
        end
        repeat (3) step();
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] a_tab [2][4];
        logic          we_tab [2][4];
        logic [DW-1:0] d_tab [2][4];
        int            c [2];
        int            g;
        a_tab[0]  = '{10'h020, 10'h021, 10'h020, 10'h021};
        a_tab[1]  = '{10'h021, 10'h020, 10'h021, 10'h020};
        we_tab[0] = '{1'b1, 1'b0, 1'b0, 1'b0};
        we_tab[1] = '{1'b1, 1'b0, 1'b0, 1'b0};
        d_tab[0]  = '{8'h11, 8'h00, 8'h00, 8'h00};
        d_tab[1]  = '{8'h22, 8'h00, 8'h00, 8'h00};
        c = '{0, 0};
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        wait_init();
        for (int i = 0; i < 7; i++) begin
            g = i % 2;
            drive0(1, we_tab[0][c[0]], a_tab[0][c[0]], d_tab[0][c[0]]);
            drive1(1, we_tab[1][c[1]], a_tab[1][c[1]], d_tab[1][c[1]]);
            #1;
            tests++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                fails++; $display("FAIL rr_grant i=%0d ready0=%b ready1=%b, required port%0d only", i, req0_ready, req1_ready, g);
            end
            if (we_tab[g][c[g]]) ref_mem[a_tab[g][c[g]]] = d_tab[g][c[g]];
            else                 push_read(g[0], a_tab[g][c[g]]);
            c[g]++;
            step();
            tests++;
            if (sram_csb0 !== 1'b0) begin
                fails++; $display("FAIL rr_access i=%0d csb=%b, required 0", i, sram_csb0);
            end
        end
        drive0(0, 0, '0, '0); drive1(0, 0, '0, '0);
        repeat (4) step();
    endtask

    task automatic test_port1_alone();
        drive1(1, 0, 10'h001, '0);
        #1;
        tests++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            fails++; $display("FAIL p1_alone ready1=%b ready0=%b, required 1 0", req1_ready, req0_ready);
        end
        push_read(1'b1, 10'h001);
        step();
        drive1(0, 0, '0, '0);
        drive0(1, 0, 10'h020, '0);
        #1;
        tests++;
        if (req0_ready !== 1'b1) begin
            fails++; $display("FAIL p0_follow ready0=%b, required 1", req0_ready);
        end
        push_read(1'b0, 10'h020);
        step();
        drive0(0, 0, '0, '0);
        repeat (4) step();
    endtask

    task automatic test_reset_mid();
        int bad;
        drive0(1, 0, 10'h010, '0);
        #1;
        tests++;
        if (req0_ready !== 1'b1) begin
            fails++; $display("FAIL mid_acc1 ready0=%b, required 1", req0_ready);
        end
        step();
        drive0(1, 0, 10'h011, '0);
        #1;
        tests++;
        if (req0_ready !== 1'b1) begin
            fails++; $display("FAIL mid_acc2 ready0=%b, required 1", req0_ready);
        end
        step();
        drive0(0, 0, '0, '0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        tests++;
        if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || sram_addr0 !== '0 || sram_din0 !== '0 ||
            rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || init_done !== 1'b0 || req0_ready !== 1'b0) begin
            fails++; $display("FAIL mid_reset_vals csb=%b web=%b addr=%h din=%h rsp=%b%b init_done=%b, required 1 1 0 0 00 0",
                              sram_csb0, sram_web0, sram_addr0, sram_din0, rsp0_valid, rsp1_valid, init_done);
        end
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) bad++;
            if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== AW'(k)) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL mid_restart got %0d bad cycles, required 0 (no rsp, clear from addr 0)", bad);
        end
    endtask

    initial begin
        test_reset();
        test_no_clear();
        test_read_clear();
        test_write_read();
        test_round_robin();
        test_port1_alone();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
